// File: rtl/pcm_test_pkg.sv
// Shared constants and types for the PCM test-pattern generator and checker.
// Pattern selects, expected levels and the checker state encoding.
package pcm_test_pkg;

    localparam logic [3:0] SEL_BYPASS  = 4'd0;
    localparam logic [3:0] SEL_POS_DC  = 4'd1;
    localparam logic [3:0] SEL_NEG_DC  = 4'd2;
    localparam logic [3:0] SEL_TRI     = 4'd3;
    localparam logic [3:0] SEL_IMPULSE = 4'd4;

    localparam logic [23:0] DC_POS      = 24'h000100;
    localparam logic [23:0] DC_NEG      = 24'h8000FF;
    localparam logic [23:0] IMPULSE_AMP = 24'h7FFF00;
    localparam logic [23:0] TRI_TOP     = 24'h7FFFFE;

    localparam logic [15:0] SPC_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_TRACK
    } state_t;

    function automatic logic [23:0] tri_inc(input logic [7:0] r);
        return {3'h0, r, 13'h0};
    endfunction

endpackage

// File: rtl/pcm_test_checker_tri_step.sv
// Triangle next-value predictor.
// Steps cur by inc in direction dir, turning around at the top/bottom limits.
module tri_step
    import pcm_test_pkg::*;
(
    input  logic [23:0] cur,
    input  logic [23:0] inc,
    input  logic        dir,
    output logic [23:0] next,
    output logic        next_dir
);

    logic [24:0] sum;
    logic [24:0] dif;
    logic        up_ok;
    logic        dn_ok;

    assign sum   = {1'b0, cur} + {1'b0, inc};
    assign dif   = {1'b0, cur} - {1'b0, inc};
    assign up_ok = sum < {1'b0, TRI_TOP};
    assign dn_ok = !dif[24] && (dif[23:0] > inc);

    // Pick the step, reversing when the limit would be crossed
    always_comb begin
        next     = sum[23:0];
        next_dir = 1'b1;
        if (dir) begin
            if (!up_ok) begin
                next     = dif[23:0];
                next_dir = 1'b0;
            end
        end else if (dn_ok) begin
            next     = dif[23:0];
            next_dir = 1'b0;
        end
    end

endmodule

// File: rtl/pcm_test_checker.sv
// Receive-side checker for the front-end test patterns.
// Acquires lock on the selected pattern and keeps error/sample statistics.
module pcm_test_checker
    import pcm_test_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SMP_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       data_out_select,
    input  logic [7:0]       triangle_inc_reg,
    input  logic             clear_stats,
    input  logic             in_valid,
    input  logic [23:0]      l_in_data,
    input  logic [23:0]      r_in_data,
    output logic             lock,
    output logic             error_flag,
    output logic [CNT_W-1:0] error_count,
    output logic [SMP_W-1:0] sample_count,
    output logic [23:0]      first_err_data,
    output logic [15:0]      impulse_period
);

    state_t      state;
    logic [3:0]  prev_sel;
    logic [23:0] cur;
    logic        dir;
    logic        have;
    logic [15:0] cnt;

    logic        accept;
    logic        sel_ok;
    logic        sel_chg;
    logic        samp_ok;
    logic [23:0] dc_exp;
    logic [23:0] inc;
    logic [23:0] up_next;
    logic        up_dir;
    logic [23:0] dn_next;
    logic        dn_dir;
    logic [23:0] tri_exp;
    logic        tri_dir;
    logic        is_imp;
    logic        imp_miss;
    logic        imp_err;
    logic [15:0] cnt_inc;
    logic        pat_err;
    logic        sample_ev;
    logic        err_ev;

    assign accept  = in_valid & run;
    assign sel_ok  = (data_out_select >= SEL_POS_DC) &&
                     (data_out_select <= SEL_IMPULSE);
    assign sel_chg = data_out_select != prev_sel;
    assign samp_ok = l_in_data == r_in_data;
    assign dc_exp  = (data_out_select == SEL_NEG_DC) ? DC_NEG : DC_POS;
    assign inc     = tri_inc(triangle_inc_reg);
    assign tri_exp = dir ? up_next : dn_next;
    assign tri_dir = dir ? up_dir : dn_dir;
    assign is_imp  = l_in_data != 24'h0;
    assign cnt_inc = (cnt == SPC_MAX) ? cnt : cnt + 16'd1;

    assign imp_miss = !is_imp &&
                      ((cnt == impulse_period) || (cnt == SPC_MAX));
    assign imp_err  = is_imp ?
                      ((l_in_data != IMPULSE_AMP) || (cnt != impulse_period)) :
                      imp_miss;

    tri_step u_up (
        .cur      (cur),
        .inc      (inc),
        .dir      (1'b1),
        .next     (up_next),
        .next_dir (up_dir)
    );

    tri_step u_dn (
        .cur      (cur),
        .inc      (inc),
        .dir      (1'b0),
        .next     (dn_next),
        .next_dir (dn_dir)
    );

    // Pattern mismatch for a sample received while tracking
    always_comb begin
        pat_err = 1'b0;
        unique case (1'b1)
            data_out_select == SEL_POS_DC:  pat_err = l_in_data != dc_exp;
            data_out_select == SEL_NEG_DC:  pat_err = l_in_data != dc_exp;
            data_out_select == SEL_TRI:     pat_err = l_in_data != tri_exp;
            data_out_select == SEL_IMPULSE: pat_err = imp_err;
            default:                        pat_err = 1'b0;
        endcase
    end

    assign sample_ev = accept && sel_ok && !sel_chg && (state == ST_TRACK);
    assign err_ev    = sample_ev && (!samp_ok || pat_err);

    // Lock state machine with per-pattern acquisition and tracking state
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            lock           <= 1'b0;
            prev_sel       <= SEL_BYPASS;
            cur            <= 24'h0;
            dir            <= 1'b1;
            have           <= 1'b0;
            cnt            <= 16'h0;
            impulse_period <= 16'h0;
        end else begin
            prev_sel <= data_out_select;
            if (!run || !sel_ok) begin
                state <= ST_IDLE;
                lock  <= 1'b0;
                have  <= 1'b0;
            end else if (state == ST_IDLE || sel_chg) begin
                state <= ST_ACQUIRE;
                lock  <= 1'b0;
                have  <= 1'b0;
            end else if (accept) begin
                unique case (state)
                    ST_ACQUIRE: begin
                        if (!samp_ok) begin
                            have <= 1'b0;
                        end else begin
                            unique case (1'b1)
                                data_out_select == SEL_TRI: begin
                                    cur  <= l_in_data;
                                    have <= 1'b1;
                                    if (have && l_in_data == up_next) begin
                                        dir   <= up_dir;
                                        state <= ST_TRACK;
                                        lock  <= 1'b1;
                                    end else if (have && l_in_data == dn_next) begin
                                        dir   <= dn_dir;
                                        state <= ST_TRACK;
                                        lock  <= 1'b1;
                                    end
                                end
                                data_out_select == SEL_IMPULSE: begin
                                    if (!is_imp) begin
                                        cnt <= cnt_inc;
                                    end else if (l_in_data != IMPULSE_AMP) begin
                                        have <= 1'b0;
                                    end else if (!have || cnt == SPC_MAX) begin
                                        have <= 1'b1;
                                        cnt  <= 16'd1;
                                    end else begin
                                        impulse_period <= cnt;
                                        cnt            <= 16'd1;
                                        state          <= ST_TRACK;
                                        lock           <= 1'b1;
                                    end
                                end
                                default: begin
                                    if (l_in_data == dc_exp) begin
                                        state <= ST_TRACK;
                                        lock  <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_TRACK: begin
                        cur <= l_in_data;
                        if (l_in_data == tri_exp) begin
                            dir <= tri_dir;
                        end
                        cnt <= (is_imp || imp_miss) ? 16'd1 : cnt_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Error and sample statistics; a clear pulse overrides a coincident error
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            error_flag     <= 1'b0;
            error_count    <= '0;
            sample_count   <= '0;
            first_err_data <= 24'h0;
        end else begin
            if (sample_ev && sample_count != '1) begin
                sample_count <= sample_count + SMP_W'(1);
            end
            if (err_ev) begin
                error_flag <= 1'b1;
                if (error_count != '1) begin
                    error_count <= error_count + CNT_W'(1);
                end
                if (!error_flag) begin
                    first_err_data <= l_in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_test_checker.sv
// Directed self-checking bench for pcm_test_checker.
// Drives inputs on the falling edge and checks outputs one falling edge later.
module tb_pcm_test_checker;

    localparam logic [23:0] TINC = 24'h020000;
    localparam logic [23:0] AMP  = 24'h7FFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  data_out_select = 4'd0;
    logic [7:0]  triangle_inc_reg = 8'h10;
    logic        clear_stats = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] l_in_data = 24'h0;
    logic [23:0] r_in_data = 24'h0;
    logic        lock;
    logic        error_flag;
    logic [15:0] error_count;
    logic [23:0] sample_count;
    logic [23:0] first_err_data;
    logic [15:0] impulse_period;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcm_test_checker #(
        .CNT_W (16),
        .SMP_W (24)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .data_out_select  (data_out_select),
        .triangle_inc_reg (triangle_inc_reg),
        .clear_stats      (clear_stats),
        .in_valid         (in_valid),
        .l_in_data        (l_in_data),
        .r_in_data        (r_in_data),
        .lock             (lock),
        .error_flag       (error_flag),
        .error_count      (error_count),
        .sample_count     (sample_count),
        .first_err_data   (first_err_data),
        .impulse_period   (impulse_period)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic send2(input logic [23:0] l, input logic [23:0] r,
                         input logic clr);
        l_in_data   = l;
        r_in_data   = r;
        in_valid    = 1'b1;
        clear_stats = clr;
        @(negedge clk);
        in_valid    = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic send(input logic [23:0] v);
        send2(v, v, 1'b0);
    endtask

    task automatic send_period(input logic [23:0] v);
        send(v);
        repeat (6) send(24'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_lock"}, 32'(lock), 32'd0);
        check({tag, "_flag"}, 32'(error_flag), 32'd0);
        check({tag, "_ecnt"}, 32'(error_count), 32'd0);
        check({tag, "_scnt"}, 32'(sample_count), 32'd0);
        check({tag, "_ferr"}, 32'(first_err_data), 32'd0);
        check({tag, "_per"}, 32'(impulse_period), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // positive DC: lock after first sample, nine counted samples
        reset = 1'b0;
        run = 1'b1;
        data_out_select = 4'd1;
        repeat (2) @(negedge clk);
        send(24'h000100);
        check("dc_lock", 32'(lock), 32'd1);
        check("dc_scnt0", 32'(sample_count), 32'd0);
        repeat (9) send(24'h000100);
        check("dc_scnt9", 32'(sample_count), 32'd9);
        check("dc_ecnt", 32'(error_count), 32'd0);

        // L != R while tracking
        send2(24'h000100, 24'h000101, 1'b0);
        check("lr_ecnt", 32'(error_count), 32'd1);
        check("lr_flag", 32'(error_flag), 32'd1);
        check("lr_ferr", 32'(first_err_data), 32'h000100);

        // clear coinciding with an error: clear wins
        send2(24'h000100, 24'h000101, 1'b1);
        check("clr_ecnt", 32'(error_count), 32'd0);
        check("clr_flag", 32'(error_flag), 32'd0);
        check("clr_scnt", 32'(sample_count), 32'd0);
        check("clr_lock", 32'(lock), 32'd1);

        // select change drops lock, then negative DC relocks
        data_out_select = 4'd2;
        @(negedge clk);
        check("sw_lock", 32'(lock), 32'd0);
        send(24'h8000FF);
        check("neg_lock", 32'(lock), 32'd1);
        send(24'h000100);
        check("neg_ecnt", 32'(error_count), 32'd1);

        // reset mid-stream with a strobe present
        reset = 1'b1;
        send(24'h8000FF);
        check_reset_vals("rst2");

        // triangle, inc 0x020000: peak 0x7E0000, trough 0x040000
        reset = 1'b0;
        data_out_select = 4'd3;
        triangle_inc_reg = 8'h10;
        repeat (2) @(negedge clk);
        send(24'h0);
        check("tri_lock1", 32'(lock), 32'd0);
        send(TINC);
        check("tri_lock2", 32'(lock), 32'd1);
        for (int k = 2; k <= 63; k++) send(TINC * 24'(k));
        for (int k = 62; k >= 2; k--) send(TINC * 24'(k));
        for (int k = 3; k <= 63; k++) send(TINC * 24'(k));
        for (int k = 62; k >= 20; k--) send(TINC * 24'(k));
        check("tri_ecnt0", 32'(error_count), 32'd0);
        check("tri_scnt", 32'(sample_count), 32'd227);
        check("tri_lock", 32'(lock), 32'd1);

        // one corrupted sample; source continues from the corrupted value
        send(24'h260001);
        check("tri_inj_ecnt", 32'(error_count), 32'd1);
        check("tri_inj_flag", 32'(error_flag), 32'd1);
        check("tri_inj_ferr", 32'(first_err_data), 32'h260001);
        send(24'h240001);
        send(24'h220001);
        send(24'h200001);
        check("tri_post_ecnt", 32'(error_count), 32'd1);

        // impulse train, spacing 7
        data_out_select = 4'd4;
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check("imp_sw_lock", 32'(lock), 32'd0);
        check("imp_clr_ecnt", 32'(error_count), 32'd0);
        send_period(AMP);
        check("imp_acq_lock", 32'(lock), 32'd0);
        send(AMP);
        check("imp_lock", 32'(lock), 32'd1);
        check("imp_per", 32'(impulse_period), 32'd7);
        repeat (6) send(24'h0);
        send_period(AMP);
        check("imp_ok_ecnt", 32'(error_count), 32'd0);
        send_period(24'h0);
        check("imp_drop_ecnt", 32'(error_count), 32'd1);
        check("imp_drop_ferr", 32'(first_err_data), 32'h0);
        send_period(AMP);
        check("imp_resync_ecnt", 32'(error_count), 32'd1);
        send_period(24'h7FFF01);
        check("imp_amp_ecnt", 32'(error_count), 32'd2);
        send_period(AMP);
        check("imp_after_ecnt", 32'(error_count), 32'd2);
        check("imp_scnt", 32'(sample_count), 32'd41);

        // run low: idle, statistics hold, strobes ignored
        run = 1'b0;
        @(negedge clk);
        check("run_lock", 32'(lock), 32'd0);
        send(AMP);
        check("run_ecnt", 32'(error_count), 32'd2);
        check("run_scnt", 32'(sample_count), 32'd41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcm_test_checker.md
# pcm_test_checker

Receive-side companion to the front-end test-pattern generator: consumes a strobed 24-bit stereo sample stream and verifies it against the selected test pattern (positive DC, negative DC, triangle, impulse train). It sits at the back end of the audio pipeline, after the filter/DSP path, or directly on the front-end output for loopback. It exposes lock, error and sample statistics as CPU-readable registers.

## Interface
Parameters:
- CNT_W, 16: width of error counter (saturating)
- SMP_W, 24: width of sample counter (saturating)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  master clock (49.152 MHz domain)
- reset  in  1  synchronous active-high reset
- run  in  1  enable; low forces IDLE, statistics hold
- data_out_select  in  4  pattern under test: 0 bypass, 1 pos DC, 2 neg DC, 3 triangle, 4 impulse, others unchecked
- triangle_inc_reg  in  8  triangle slope; increment = {3'h0, reg, 13'h0}
- clear_stats  in  1  one-cycle pulse, clears counters and capture registers
- in_valid  in  1  one-cycle sample strobe
- l_in_data, r_in_data  in  24 each  sample data
- lock  out  1  pattern acquired and tracking
- error_flag  out  1  sticky, set on any mismatch while locked
- error_count  out  CNT_W  mismatches while locked, saturates at all-ones
- sample_count  out  SMP_W  samples checked while locked, saturates
- first_err_data  out  24  left sample of first error since clear
- impulse_period  out  16  learned impulse spacing in samples

## Operation
- States: IDLE, ACQUIRE, TRACK. reset, run=0, or data_out_select outside 1..4 -> IDLE.
- Any change of data_out_select while running -> ACQUIRE next cycle; lock drops; statistics hold.
- IDLE -> ACQUIRE when run=1 and select in 1..4.
- Every accepted sample: if L != R, it counts as a mismatch (TRACK) or restarts acquisition (ACQUIRE).
- Pos DC (1): expect 24'h000100. Neg DC (2): expect 24'h8000FF. ACQUIRE -> TRACK on first matching sample.
- Triangle (3): ACQUIRE stores first sample as seed. On second sample compute both candidates: up-step (cur+inc if < 24'h7FFFFE, else cur-inc with turn) and down-step (cur-inc if result > inc, else cur+inc with turn). A match sets direction and moves to TRACK. No match reseeds. TRACK predicts with the stored direction. On mismatch: count, reseed prediction from the received sample, keep direction.
- Impulse (4): a nonzero sample must equal 24'h7FFF00, all others 0. ACQUIRE waits for two impulses and latches their spacing into impulse_period, then TRACK. In TRACK, an impulse at the wrong spacing, missing at the expected spacing, or with wrong amplitude counts as an error; the spacing counter resynchronises on every received impulse. The spacing counter saturates at 16'hFFFF, which is treated as missing.
- Bypass (0): no checking, lock=0.
- On error in TRACK: error_count increments (saturating) and error_flag sets. first_err_data is captured only if error_flag was clear.
- clear_stats clears error_count, sample_count, error_flag and first_err_data. It does not affect state. If clear_stats and an error coincide, the clear wins and that error is dropped.

## Timing
- All outputs are registered. Reset values: lock 0, error_flag 0, counters 0, first_err_data 0, impulse_period 0.
- Statistics and lock update on the clk edge after the in_valid cycle (1-cycle latency).
- in_valid is honoured only when run=1 and reset=0. Back-to-back strobes on consecutive cycles must be accepted.
- Lock latency: DC takes 1 sample, triangle 2 samples, impulse takes the second impulse.
- Reset mid-TRACK: everything returns to reset values on the next edge, regardless of in_valid.
- run low mid-TRACK: IDLE, lock 0, counters hold.

## Structure
- Shared package pcm_test_pkg holds mode constants (SEL_BYPASS..SEL_IMPULSE), DC_POS, DC_NEG, IMPULSE_AMP, TRI_TOP = 24'h7FFFFE, and the state enum. The generator uses the same package.
- One sub-module, tri_step: combinational next-value predictor. Inputs are cur, inc and dir; outputs are next and next_dir. It is instantiated twice for acquisition and reused in TRACK.

## Test plan
- Select 1, 10 strobes of 24'h000100 on L/R -> lock after first; sample_count=9; error_count=0.
- Select 3, inc reg 8'h10 (inc 24'h020000), ideal triangle across 3 turnarounds -> lock at sample 2; zero errors through both peak (near 24'h7FFFFE) and trough.
- Select 3, locked, inject one sample +1 -> error_count=1; error_flag=1; first_err_data=corrupted value; following samples error-free.
- Select 4, impulses every 7 samples -> impulse_period=7, lock. Drop one impulse -> error_count=1. Also drive amplitude 24'h7FFF01 -> error.
- L=24'h000100, R=24'h000101 in TRACK -> error. In the same cycle as clear_stats -> counters 0, flag 0.
- Switch select 1->2 while locked, then pulse reset mid-stream -> lock drops next cycle. After reset, all outputs are at reset values.
